// File: rtl/command_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : command_input_conditioner
// Purpose  : Conditions front-panel / PMOD command inputs for the Mandelbrot
//            rendering engine. It synchronises and debounces six command
//            bits into clean levels plus one-cycle press pulses. It also
//            decodes a quadrature encoder into one-cycle detent steps with a
//            direction flag and flags illegal transitions.
// Macro    : AUTO_REPEAT_EN - when defined, held buttons also emit
//            auto-repeat pulses (REPEAT_DELAY / REPEAT_PERIOD). When it is
//            undefined, btn_pulse carries press pulses only.
// Ports    : CLK        in   render clock, rising edge
//            SYS_RESET  in   synchronous active-high reset
//            btn_raw    in   [5:0] raw active-high command bits (async)
//            enc_a/b    in   raw quadrature phases (async)
//            btn_level  out  [5:0] debounced levels
//            btn_pulse  out  [5:0] one-cycle press / repeat pulses
//            enc_step   out  one-cycle pulse per full detent
//            enc_dir    out  step direction (1 = CW), valid with enc_step
//            enc_error  out  one-cycle pulse on an illegal AB transition
// Revision : 1.0 - initial release
// ============================================================================
module command_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int ENC_FILTER      = 64
) (
    input  logic       CLK,
    input  logic       SYS_RESET,
    input  logic [5:0] btn_raw,
    input  logic       enc_a,
    input  logic       enc_b,
    output logic [5:0] btn_level,
    output logic [5:0] btn_pulse,
    output logic       enc_step,
    output logic       enc_dir,
    output logic       enc_error
);

    localparam int             DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam int             EF_W    = $clog2(ENC_FILTER + 1);
    localparam logic [EF_W-1:0] EF_FULL = EF_W'(ENC_FILTER);

    // Detent accumulator must represent +4 and -4.
    localparam logic signed [3:0] ACC_MAX = 4'sb0100;
    localparam logic signed [3:0] ACC_MIN = 4'sb1100;

`ifdef AUTO_REPEAT_EN
    localparam int RT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RT_W   = $clog2(RT_MAX) + 1;
    localparam logic [RT_W-1:0] RD_LAST = RT_W'(REPEAT_DELAY - 1);
    localparam logic [RT_W-1:0] RP_LAST = RT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;
`else
    // Repeat timing has no effect in this build.
    if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_no_repeat
    end
`endif

    // ------------------------------------------------------------------
    // Two-flop synchroniser: {enc_a, enc_b, btn_raw}
    // ------------------------------------------------------------------
    logic [7:0] r_meta;
    logic [7:0] r_sync;

    always_ff @(posedge CLK) begin
        if (SYS_RESET) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= {enc_a, enc_b, btn_raw};
            r_sync <= r_meta;
        end
    end

    // ------------------------------------------------------------------
    // Per-button debounce, press pulse and optional auto-repeat
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 6; gi++) begin : g_btn
        logic [DB_W-1:0] r_db_cnt;
        logic            r_level;
        logic            r_press;
        logic            w_sync;
        logic            w_flip;
        logic            w_rise;
        logic            w_pulse;

        assign w_sync = r_sync[gi];
        // Level flips once the disagreement has persisted long enough.
        assign w_flip = (w_sync != r_level) && (r_db_cnt == DB_LAST);
        assign w_rise = w_flip & w_sync;

        always_ff @(posedge CLK) begin
            if (SYS_RESET) begin
                r_db_cnt <= '0;
                r_level  <= 1'b0;
                r_press  <= 1'b0;
            end else begin
                // Press pulse is registered on the same edge as the level
                // rise so both appear in the same cycle.
                r_press <= w_rise;
                if (w_sync == r_level) begin
                    r_db_cnt <= '0;
                end else if (w_flip) begin
                    r_level  <= w_sync;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
            end
        end

`ifdef AUTO_REPEAT_EN
        rpt_state_t      r_state;
        logic [RT_W-1:0] r_timer;
        logic            r_rpt;
        logic            w_level_nxt;

        // The FSM follows the level being written this edge, so it starts
        // timing on the press edge and never fires on the release edge.
        assign w_level_nxt = w_flip ? w_sync : r_level;

        always_ff @(posedge CLK) begin
            if (SYS_RESET) begin
                r_state <= RPT_IDLE;
                r_timer <= '0;
                r_rpt   <= 1'b0;
            end else begin
                r_rpt <= 1'b0;
                if (!w_level_nxt) begin
                    r_state <= RPT_IDLE;
                    r_timer <= '0;
                end else begin
                    case (r_state)
                        RPT_IDLE: begin
                            if (w_rise) begin
                                r_state <= RPT_DELAY;
                                r_timer <= '0;
                            end
                        end
                        RPT_DELAY: begin
                            if (r_timer == RD_LAST) begin
                                r_rpt   <= 1'b1;
                                r_state <= RPT_REPEAT;
                                r_timer <= '0;
                            end else begin
                                r_timer <= r_timer + RT_W'(1);
                            end
                        end
                        RPT_REPEAT: begin
                            if (r_timer == RP_LAST) begin
                                r_rpt   <= 1'b1;
                                r_timer <= '0;
                            end else begin
                                r_timer <= r_timer + RT_W'(1);
                            end
                        end
                        default: begin
                            r_state <= RPT_IDLE;
                            r_timer <= '0;
                        end
                    endcase
                end
            end
        end

        assign w_pulse = r_press | r_rpt;
`else
        assign w_pulse = r_press;
`endif

        assign btn_level[gi] = r_level;
        assign btn_pulse[gi] = w_pulse;
    end

    // ------------------------------------------------------------------
    // Encoder glitch filter: a candidate AB value must be seen for
    // ENC_FILTER consecutive samples before it is accepted.
    // ------------------------------------------------------------------
    logic [1:0]      w_ab;
    logic [1:0]      r_cand;
    logic [EF_W-1:0] r_ef_cnt;
    logic [1:0]      r_prev;
    logic            r_prev_valid;
    logic            w_acc;

    assign w_ab  = r_sync[7:6];
    assign w_acc = (r_ef_cnt == EF_FULL) && (!r_prev_valid || (r_cand != r_prev));

    always_ff @(posedge CLK) begin
        if (SYS_RESET) begin
            r_cand   <= 2'b00;
            r_ef_cnt <= '0;
        end else if (w_ab != r_cand) begin
            r_cand   <= w_ab;
            r_ef_cnt <= EF_W'(1);
        end else if (r_ef_cnt != EF_FULL) begin
            r_ef_cnt <= r_ef_cnt + EF_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Quadrature decode. AB is mapped to a position on the Gray cycle
    // 00,01,11,10 so a modulo-4 difference gives the step direction:
    // 1 = CW, 3 = CCW, 2 = both phases changed (illegal).
    // ------------------------------------------------------------------
    function automatic logic [1:0] quad_pos(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    logic [1:0]        w_delta;
    logic signed [3:0] r_acc;
    logic signed [3:0] w_acc_nxt;

    assign w_delta = quad_pos(r_cand) - quad_pos(r_prev);

    always_comb begin
        w_acc_nxt = r_acc;
        if (w_delta == 2'd1) begin
            w_acc_nxt = (r_acc == ACC_MAX) ? ACC_MAX : r_acc + 4'sd1;
        end else if (w_delta == 2'd3) begin
            w_acc_nxt = (r_acc == ACC_MIN) ? ACC_MIN : r_acc - 4'sd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (SYS_RESET) begin
            r_prev       <= 2'b00;
            r_prev_valid <= 1'b0;
            r_acc        <= '0;
            enc_step     <= 1'b0;
            enc_dir      <= 1'b0;
            enc_error    <= 1'b0;
        end else begin
            enc_step  <= 1'b0;
            enc_dir   <= 1'b0;
            enc_error <= 1'b0;
            if (w_acc) begin
                r_prev       <= r_cand;
                r_prev_valid <= 1'b1;
                // The very first accepted value only seeds r_prev.
                if (r_prev_valid) begin
                    if (w_delta == 2'd2) begin
                        r_acc     <= '0;
                        enc_error <= 1'b1;
                    end else if (r_cand == 2'b00) begin
                        r_acc <= '0;
                        if (w_acc_nxt == ACC_MAX) begin
                            enc_step <= 1'b1;
                            enc_dir  <= 1'b1;
                        end else if (w_acc_nxt == ACC_MIN) begin
                            enc_step <= 1'b1;
                        end
                    end else begin
                        r_acc <= w_acc_nxt;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_command_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_command_input_conditioner
// Purpose  : Self-checking bench for command_input_conditioner. Stimulus
//            pushes expected output events into a queue; a monitor pops and
//            compares whenever a pulse output is active.
// Revision : 1.0 - initial release
// ============================================================================
module tb_command_input_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int EF = 2;

    logic       CLK = 1'b0;
    logic       SYS_RESET;
    logic [5:0] btn_raw;
    logic       enc_a;
    logic       enc_b;
    logic [5:0] btn_level;
    logic [5:0] btn_pulse;
    logic       enc_step;
    logic       enc_dir;
    logic       enc_error;

    command_input_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .ENC_FILTER      (EF)
    ) dut (
        .CLK       (CLK),
        .SYS_RESET (SYS_RESET),
        .btn_raw   (btn_raw),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse),
        .enc_step  (enc_step),
        .enc_dir   (enc_dir),
        .enc_error (enc_error)
    );

    always #5 CLK = ~CLK;

    // cyc = number of rising edges seen; sampled on falling edges.
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct packed {
        int         at;
        logic [5:0] pulse;
        logic       step;
        logic       dir;
        logic       err;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    ev_t drain_e;
    int  n_checks = 0;
    int  n_fail   = 0;

    function automatic ev_t mk(input int at, input logic [5:0] p,
                               input logic s, input logic d, input logic e);
        ev_t r;
        r.at    = at;
        r.pulse = p;
        r.step  = s;
        r.dir   = d;
        r.err   = e;
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic drive_ab(input logic [1:0] v);
        {enc_a, enc_b} = v;
        tick(5);
    endtask

    // Monitor: every active pulse cycle is one observed event.
    always @(negedge CLK) begin
        if ((btn_pulse != 6'd0) || enc_step || enc_error) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: cycle %0d pulse=%b step=%b dir=%b err=%b, none expected",
                         cyc, btn_pulse, enc_step, enc_dir, enc_error);
            end else begin
                mon_e = exp_q.pop_front();
                if ((mon_e.at != cyc) || (mon_e.pulse != btn_pulse) || (mon_e.step != enc_step) ||
                    (mon_e.err != enc_error) || (enc_step && (mon_e.dir != enc_dir))) begin
                    n_fail++;
                    $display("FAIL event: got cycle %0d pulse=%b step=%b dir=%b err=%b, expected cycle %0d pulse=%b step=%b dir=%b err=%b",
                             cyc, btn_pulse, enc_step, enc_dir, enc_error,
                             mon_e.at, mon_e.pulse, mon_e.step, mon_e.dir, mon_e.err);
                end
            end
        end
    end

    initial begin
        int t0;
        SYS_RESET = 1'b1;
        btn_raw   = 6'd0;
        enc_a     = 1'b0;
        enc_b     = 1'b0;

        // Reset state
        tick(3);
        check("reset_level", btn_level, 0);
        check("reset_pulse", btn_pulse, 0);
        check("reset_enc",   {enc_step, enc_dir, enc_error}, 0);
        SYS_RESET = 1'b0;
        tick(10);

        // Clean press on bit 2, held 10 cycles
        t0 = cyc;
        btn_raw[2] = 1'b1;
        exp_q.push_back(mk(t0 + 6, 6'b000100, 1'b0, 1'b0, 1'b0));
        tick(5);
        check("press_level_early", btn_level, 6'b000000);
        tick(1);
        check("press_level", btn_level, 6'b000100);
        tick(4);
        btn_raw[2] = 1'b0;
        tick(5);
        check("release_level_held", btn_level, 6'b000100);
        tick(1);
        check("release_level", btn_level, 6'b000000);
        tick(6);

        // Glitch of DB-1 cycles on bit 0: rejected
        btn_raw[0] = 1'b1;
        tick(3);
        btn_raw[0] = 1'b0;
        check("glitch_level_mid", btn_level, 6'b000000);
        tick(8);
        check("glitch_level", btn_level, 6'b000000);

        // Pulse of exactly DB cycles on bit 3: accepted
        t0 = cyc;
        btn_raw[3] = 1'b1;
        exp_q.push_back(mk(t0 + 6, 6'b001000, 1'b0, 1'b0, 1'b0));
        tick(4);
        btn_raw[3] = 1'b0;
        tick(2);
        check("boundary_level_high", btn_level, 6'b001000);
        tick(4);
        check("boundary_level_low", btn_level, 6'b000000);
        tick(6);

        // Simultaneous press of bits 0 and 4
        t0 = cyc;
        btn_raw = 6'b010001;
        exp_q.push_back(mk(t0 + 6, 6'b010001, 1'b0, 1'b0, 1'b0));
        tick(8);
        btn_raw = 6'b000000;
        tick(12);
        check("simul_release", btn_level, 6'b000000);

        // Long hold on bit 5 (60 cycles)
        t0 = cyc;
        btn_raw[5] = 1'b1;
        exp_q.push_back(mk(t0 + 6, 6'b100000, 1'b0, 1'b0, 1'b0));
`ifdef AUTO_REPEAT_EN
        exp_q.push_back(mk(t0 + 26, 6'b100000, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(t0 + 34, 6'b100000, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(t0 + 42, 6'b100000, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(t0 + 50, 6'b100000, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(t0 + 58, 6'b100000, 1'b0, 1'b0, 1'b0));
`endif
        tick(60);
        btn_raw[5] = 1'b0;
        tick(5);
        check("hold_level_before_release", btn_level, 6'b100000);
        tick(1);
        check("hold_level_released", btn_level, 6'b000000);
        tick(30);

        // Encoder: full CW detent -> step, dir=1
        drive_ab(2'b01);
        drive_ab(2'b11);
        drive_ab(2'b10);
        exp_q.push_back(mk(cyc + 5, 6'd0, 1'b1, 1'b1, 1'b0));
        drive_ab(2'b00);
        tick(5);

        // Full CCW detent -> step, dir=0
        drive_ab(2'b10);
        drive_ab(2'b11);
        drive_ab(2'b01);
        exp_q.push_back(mk(cyc + 5, 6'd0, 1'b1, 1'b0, 1'b0));
        drive_ab(2'b00);
        tick(5);

        // Half step out and back: no step
        drive_ab(2'b01);
        drive_ab(2'b00);
        tick(5);

        // Illegal 00->11, return to 00 without a full detent, then full CCW
        exp_q.push_back(mk(cyc + 5, 6'd0, 1'b0, 1'b0, 1'b1));
        drive_ab(2'b11);
        drive_ab(2'b01);
        drive_ab(2'b00);
        drive_ab(2'b10);
        drive_ab(2'b11);
        drive_ab(2'b01);
        exp_q.push_back(mk(cyc + 5, 6'd0, 1'b1, 1'b0, 1'b0));
        drive_ab(2'b00);
        tick(10);

        // Reset in the middle of a held press
        t0 = cyc;
        btn_raw[1] = 1'b1;
        exp_q.push_back(mk(t0 + 6, 6'b000010, 1'b0, 1'b0, 1'b0));
        tick(10);
        check("pre_reset_level", btn_level, 6'b000010);
        SYS_RESET = 1'b1;
        tick(1);
        check("midreset_level", btn_level, 6'b000000);
        check("midreset_outputs", {btn_pulse, enc_step, enc_dir, enc_error}, 0);
        SYS_RESET = 1'b0;
        exp_q.push_back(mk(t0 + 17, 6'b000010, 1'b0, 1'b0, 1'b0));
        tick(6);
        check("post_reset_level", btn_level, 6'b000010);
        tick(3);
        btn_raw[1] = 1'b0;
        tick(30);
        check("final_level", btn_level, 6'b000000);

        // Any expected event never seen is a failure
        while (exp_q.size() > 0) begin
            drain_e = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_event: expected cycle %0d pulse=%b step=%b dir=%b err=%b, not observed",
                     drain_e.at, drain_e.pulse, drain_e.step, drain_e.dir, drain_e.err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
